// File: rtl/hdmi_packet_scheduler.sv
// Data-island packet scheduler: urgent packet, then lowest pending enabled slot, else NULL; 1-cycle selection latency.
// Define HDMI_PACKET_SCHEDULER_MISS_COUNT_EN to build the saturating deadline-miss counter.
module hdmi_packet_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int FIELD_PERIOD = 1
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       video_field_end,
  input  logic                       packet_enable,
  input  logic [4:0]                 packet_pixel_counter,
  input  logic [NUM_SLOTS-1:0]       slot_enable,
  input  logic [24*NUM_SLOTS-1:0]    slot_header,
  input  logic [224*NUM_SLOTS-1:0]   slot_sub,
  input  logic                       urgent_req,
  input  logic [23:0]                urgent_header,
  input  logic [223:0]               urgent_sub,
  output logic                       urgent_ack,
  output logic [23:0]                header,
  output logic [3:0][55:0]           sub,
  output logic [NUM_SLOTS-1:0]       grant,
  output logic                       missed,
  output logic [7:0]                 missed_count
);

  localparam int FW = (FIELD_PERIOD > 1) ? $clog2(FIELD_PERIOD) : 1;
  localparam logic [FW-1:0] LAST_FIELD = FW'(FIELD_PERIOD - 1);

  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [FW-1:0]        field_cnt_q, field_cnt_d;
  logic                 urgent_busy_q, urgent_busy_d;
  logic                 blackout_q, blackout_d;
  logic [23:0]          header_q, header_d;
  logic [3:0][55:0]     sub_q, sub_d;
  logic [NUM_SLOTS-1:0] grant_q, grant_d;
  logic                 missed_q, missed_d;

  logic [NUM_SLOTS-1:0] eligible, pick;
  logic [23:0]          pick_header;
  logic [223:0]         pick_sub;
  logic                 deadline;

  assign urgent_ack = urgent_busy_q && (packet_pixel_counter == 5'd31) && !reset;
  assign deadline   = video_field_end && (field_cnt_q == LAST_FIELD);

  // Lowest set bit of the eligible mask is the winning slot.
  assign eligible = pending_q & slot_enable;
  assign pick     = eligible & ~(eligible - NUM_SLOTS'(1));

  always_comb begin
    pick_header = '0;
    pick_sub    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (pick[i]) begin
        pick_header = pick_header | slot_header[24*i +: 24];
        pick_sub    = pick_sub | slot_sub[224*i +: 224];
      end
    end
  end

  always_comb begin
    pending_d     = pending_q;
    field_cnt_d   = field_cnt_q;
    urgent_busy_d = urgent_busy_q;
    blackout_d    = 1'b0;
    header_d      = header_q;
    sub_d         = sub_q;
    grant_d       = '0;
    missed_d      = 1'b0;

    if (urgent_ack) begin
      urgent_busy_d = 1'b0;
      blackout_d    = 1'b1;
    end

    if (video_field_end) begin
      if (deadline) begin
        missed_d    = |eligible;
        pending_d   = '1;
        field_cnt_d = '0;
      end else begin
        field_cnt_d = field_cnt_q + FW'(1);
      end
    end

    // A window that coincides with a field end always carries NULL.
    if (packet_enable) begin
      header_d = '0;
      sub_d    = '0;
      if (!video_field_end) begin
        if (urgent_req && !urgent_busy_q && !blackout_q) begin
          header_d      = urgent_header;
          sub_d         = urgent_sub;
          urgent_busy_d = 1'b1;
        end else if (|eligible) begin
          header_d  = pick_header;
          sub_d     = pick_sub;
          pending_d = pending_q & ~pick;
          grant_d   = pick;
        end
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      pending_q     <= '1;
      field_cnt_q   <= '0;
      urgent_busy_q <= 1'b0;
      blackout_q    <= 1'b0;
      header_q      <= '0;
      sub_q         <= '0;
      grant_q       <= '0;
      missed_q      <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      field_cnt_q   <= field_cnt_d;
      urgent_busy_q <= urgent_busy_d;
      blackout_q    <= blackout_d;
      header_q      <= header_d;
      sub_q         <= sub_d;
      grant_q       <= grant_d;
      missed_q      <= missed_d;
    end
  end

  assign header = header_q;
  assign sub    = sub_q;
  assign grant  = grant_q;
  assign missed = missed_q;

`ifdef HDMI_PACKET_SCHEDULER_MISS_COUNT_EN
  logic [7:0] missed_count_q;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      missed_count_q <= 8'd0;
    end else if (missed_d && (missed_count_q != 8'hFF)) begin
      missed_count_q <= missed_count_q + 8'd1;
    end
  end

  assign missed_count = missed_count_q;
`else
  assign missed_count = 8'd0;
`endif

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Scoreboard bench for hdmi_packet_scheduler (NUM_SLOTS=3, FIELD_PERIOD=2) with directed vectors.
module tb_hdmi_packet_scheduler;

  localparam int NS = 3;
`ifdef HDMI_PACKET_SCHEDULER_MISS_COUNT_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif
  localparam logic [223:0] U_SUB = {56'h44_0000_0000_00A4, 56'h33_0000_0000_00A3,
                                    56'h22_0000_0000_00A2, 56'h11_0000_0000_00A1};

  logic              clk_pixel = 1'b0;
  logic              reset = 1'b1;
  logic              video_field_end = 1'b0;
  logic              packet_enable = 1'b0;
  logic [4:0]        packet_pixel_counter = 5'd0;
  logic [NS-1:0]     slot_enable = 3'b111;
  logic [24*NS-1:0]  slot_header;
  logic [224*NS-1:0] slot_sub;
  logic              urgent_req = 1'b0;
  logic [23:0]       urgent_header = 24'h000001;
  logic [223:0]      urgent_sub = U_SUB;
  logic              urgent_ack;
  logic [23:0]       header;
  logic [3:0][55:0]  sub;
  logic [NS-1:0]     grant;
  logic              missed;
  logic [7:0]        missed_count;

  hdmi_packet_scheduler #(.NUM_SLOTS(NS), .FIELD_PERIOD(2)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .video_field_end(video_field_end),
    .packet_enable(packet_enable), .packet_pixel_counter(packet_pixel_counter),
    .slot_enable(slot_enable), .slot_header(slot_header), .slot_sub(slot_sub),
    .urgent_req(urgent_req), .urgent_header(urgent_header), .urgent_sub(urgent_sub),
    .urgent_ack(urgent_ack), .header(header), .sub(sub), .grant(grant),
    .missed(missed), .missed_count(missed_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct { logic [23:0] h; logic [NS-1:0] g; logic [223:0] s; } sel_t;
  typedef struct { int cyc; logic [7:0] mc; } miss_t;

  sel_t  sel_q[$];
  miss_t miss_q[$];
  int    ack_q[$];
  int    nchk = 0;
  int    nerr = 0;
  int    cyc = 0;
  logic  pe_d = 1'b0;
  logic [7:0] exp_mc = 8'd0;
  sel_t  mon_s;
  miss_t mon_m;
  int    mon_a;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [223:0] slot_pat(input int i);
    logic [223:0] v = '0;
    for (int j = 0; j < 4; j++) v[56*j +: 56] = 56'h5A00_0000_0000 + 56'(16 * i + j);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic sel(input logic [23:0] h, input logic [NS-1:0] g, input logic [223:0] s);
    sel_q.push_back('{h: h, g: g, s: s});
    packet_enable = 1'b1;
    tick();
    packet_enable = 1'b0;
  endtask

  task automatic sel_slot(input int i);
    sel(24'h000082 + 24'(i), NS'(1 << i), slot_pat(i));
  endtask

  task automatic fe(input bit miss);
    if (miss) begin
      if (MC_EN) exp_mc++;
      miss_q.push_back('{cyc: cyc + 1, mc: exp_mc});
    end
    video_field_end = 1'b1;
    tick();
    video_field_end = 1'b0;
  endtask

  always @(posedge clk_pixel) begin
    cyc  <= cyc + 1;
    pe_d <= packet_enable && !reset;
  end

  // Monitor: selections, acks and misses are popped as the DUT presents them.
  always @(negedge clk_pixel) begin
    if (!reset) begin
      if (pe_d) begin
        if (sel_q.size() == 0) chk("sel_unexpected", 1, 0);
        else begin
          mon_s = sel_q.pop_front();
          chk("sel_header", 256'(header), 256'(mon_s.h));
          chk("sel_grant", 256'(grant), 256'(mon_s.g));
          chk("sel_sub", 256'(sub), 256'(mon_s.s));
        end
      end else if (grant != '0) begin
        chk("idle_grant", 256'(grant), 0);
      end
      if (urgent_ack) begin
        if (ack_q.size() == 0) chk("ack_unexpected_cycle", 256'(cyc), 0);
        else begin
          mon_a = ack_q.pop_front();
          chk("ack_cycle", 256'(cyc), 256'(mon_a));
        end
      end
      if (missed) begin
        if (miss_q.size() == 0) chk("missed_unexpected_cycle", 256'(cyc), 0);
        else begin
          mon_m = miss_q.pop_front();
          chk("missed_cycle", 256'(cyc), 256'(mon_m.cyc));
          chk("missed_count", 256'(missed_count), 256'(mon_m.mc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    slot_header = {24'h000084, 24'h000083, 24'h000082};
    for (int i = 0; i < NS; i++) slot_sub[224*i +: 224] = slot_pat(i);

    tick(); tick(); tick();
    reset = 1'b0;
    @(negedge clk_pixel);
    chk("rst_header", 256'(header), 0);
    chk("rst_sub", 256'(sub), 0);
    chk("rst_grant", 256'(grant), 0);
    chk("rst_missed", 256'(missed), 0);
    chk("rst_missed_count", 256'(missed_count), 0);
    chk("rst_urgent_ack", 256'(urgent_ack), 0);
    tick();

    // Basic priority order, then NULL once all slots are sent.
    sel_slot(0); sel_slot(1); sel_slot(2); sel(24'h0, 3'b000, 224'h0);
    fe(0); fe(0);

    // Two-field period: slot 2 left unsent at the deadline.
    sel_slot(0); fe(0);
    sel_slot(1); fe(1);

    // Urgent preempts slot 0; blackout after the ack hands the next window to slot 0.
    urgent_req = 1'b1;
    sel(24'h000001, 3'b000, U_SUB);
    packet_pixel_counter = 5'd10; tick(); tick();
    packet_pixel_counter = 5'd31;
    ack_q.push_back(cyc);
    tick();
    packet_pixel_counter = 5'd0;
    sel_slot(0);
    urgent_req = 1'b0;
    tick();

    // Field end coincident with packet_enable: NULL window, deadline reloads pending.
    fe(0);
    exp_mc = MC_EN ? exp_mc + 8'd1 : exp_mc;
    miss_q.push_back('{cyc: cyc + 1, mc: exp_mc});
    sel_q.push_back('{h: 24'h0, g: 3'b000, s: 224'h0});
    video_field_end = 1'b1; packet_enable = 1'b1;
    tick();
    video_field_end = 1'b0; packet_enable = 1'b0;
    sel_slot(0); sel_slot(1); sel_slot(2);

    // Disabled slot keeps its pending bit and is sent once re-enabled.
    fe(0); fe(0);
    slot_enable = 3'b101;
    sel_slot(0); sel_slot(2); sel(24'h0, 3'b000, 224'h0);
    slot_enable = 3'b111;
    sel_slot(1);
    fe(0); fe(0);

    // Reset in the middle of an urgent packet aborts it without an ack.
    urgent_req = 1'b1;
    sel(24'h000001, 3'b000, U_SUB);
    packet_pixel_counter = 5'd10; tick();
    reset = 1'b1; urgent_req = 1'b0; tick();
    packet_pixel_counter = 5'd31; tick();
    reset = 1'b0; tick();
    packet_pixel_counter = 5'd0;
    @(negedge clk_pixel);
    chk("abort_header", 256'(header), 0);
    chk("abort_sub", 256'(sub), 0);
    chk("abort_missed_count", 256'(missed_count), 0);
    tick();
    sel_slot(0); sel_slot(1); sel_slot(2);

    tick(); tick(); tick();
    chk("sel_queue_drained", 256'(sel_q.size()), 0);
    chk("ack_queue_drained", 256'(ack_q.size()), 0);
    chk("miss_queue_drained", 256'(miss_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
